// File: rtl/udp_echo_pkg.sv
// udp_echo_pkg: mode encodings and tx-side enums shared by the UDP echo buffer
package udp_echo_pkg;
  typedef enum logic [1:0] {MODE_ECHO, MODE_PAT, MODE_BOTH, MODE_OFF} mode_e;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_SEND, TX_GAP} tx_state_e;
  typedef enum logic {SRC_ECHO, SRC_PAT} src_e;
endpackage

// File: rtl/udp_echo_buffer_if.sv
// udp_echo_buffer_if: rx payload stream plus tx engine request/data handshake
interface udp_echo_buffer_if;
  logic udp_rec_data_valid;
  logic [7:0] udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic udp_rec_err;
  logic app_tx_req;
  logic [15:0] app_tx_length;
  logic app_tx_ack;
  logic app_tx_data_req;
  logic [7:0] app_tx_data;
  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, udp_rec_err, app_tx_ack, app_tx_data_req,
    input app_tx_req, app_tx_length, app_tx_data
  );
  modport slave (
    input udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, udp_rec_err, app_tx_ack, app_tx_data_req,
    output app_tx_req, app_tx_length, app_tx_data
  );
endinterface

// File: rtl/udp_echo_ram.sv
// udp_echo_ram: simple dual-port byte RAM with registered read
module udp_echo_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    q
);
  logic [7:0] mem [1 << AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/udp_echo_buffer.sv
// udp_echo_buffer: packet-buffered UDP echo with optional periodic test-pattern source
module udp_echo_buffer import udp_echo_pkg::*; #(
  parameter int BUF_AW     = 11,
  parameter int PQ_AW      = 3,
  parameter int MIN_TX_LEN = 18,
  parameter int PAT_LEN    = 64,
  parameter int PAT_PERIOD = 125_000_000,
  parameter int IFG_CYCLES = 12
) (
  input  logic              rgmii_clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  udp_echo_buffer_if.slave  bus,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic              busy
);
  localparam int BUF_SZ = 1 << BUF_AW;
  localparam int PQ_SZ = 1 << PQ_AW;
  localparam logic [BUF_AW:0] B_ONE = 1;
  localparam logic [PQ_AW:0] PQ_ONE = 1;
  logic [BUF_AW:0] wr_ptr, cwr, rd_ptr, used;
  logic [PQ_AW:0] pq_wr, pq_rd;
  logic [15:0] pq [PQ_SZ];
  logic [16:0] free_b;
  logic rx_prev, rx_acc, rx_bad;
  logic [15:0] rx_len, rx_cnt;
  logic sop, eop, pq_full, pq_empty, accept, commit, drop, ram_we, ram_re;
  tx_state_e state;
  src_e src;
  logic [15:0] tx_len, len_r, idx, gap, nlen;
  logic echo_go, pat_go, last, tick, pat_pending;
  logic [31:0] pat_tmr;
  logic [7:0] seq, d_byte, ram_q;
  logic d_valid, d_pad, d_pat;
  logic [BUF_AW-1:0] rd_addr;
  // free space counts only committed-but-unread bytes; an in-flight rx packet never reserves space
  assign used = cwr - rd_ptr;
  assign free_b = 17'(BUF_SZ) - 17'(used);
  assign sop = bus.udp_rec_data_valid && !rx_prev;
  assign eop = !bus.udp_rec_data_valid && rx_prev;
  assign pq_empty = pq_wr == pq_rd;
  assign pq_full = pq_wr[PQ_AW] != pq_rd[PQ_AW] && pq_wr[PQ_AW-1:0] == pq_rd[PQ_AW-1:0];
  assign accept = bus.udp_rec_data_length != 16'd0 && {1'b0, bus.udp_rec_data_length} <= free_b &&
                  !pq_full && (mode == MODE_ECHO || mode == MODE_BOTH);
  assign ram_we = bus.udp_rec_data_valid && (sop ? accept : rx_acc && rx_cnt < rx_len);
  assign commit = eop && rx_acc && !rx_bad && !bus.udp_rec_err && rx_cnt == rx_len;
  assign drop = (sop && !accept) || (eop && rx_acc && !commit);
  assign echo_go = !pq_empty && mode != MODE_OFF;
  assign pat_go = pat_pending && (mode == MODE_PAT || mode == MODE_BOTH);
  assign nlen = echo_go ? pq[pq_rd[PQ_AW-1:0]] : 16'(PAT_LEN);
  assign last = bus.app_tx_data_req && idx == tx_len - 16'd1;
  assign tick = pat_tmr == 32'(PAT_PERIOD - 1);
  assign ram_re = state == TX_SEND && bus.app_tx_data_req;
  assign rd_addr = rd_ptr[BUF_AW-1:0] + idx[BUF_AW-1:0];
  assign bus.app_tx_req = state == TX_REQ;
  assign bus.app_tx_length = tx_len;
  assign bus.app_tx_data = d_valid && !d_pad ? (d_pat ? d_byte : ram_q) : 8'h00;
  assign busy = state != TX_IDLE;
  udp_echo_ram #(.AW(BUF_AW)) u_ram (
    .clk(rgmii_clk), .we(ram_we), .waddr(wr_ptr[BUF_AW-1:0]), .wdata(bus.udp_rec_rdata),
    .re(ram_re), .raddr(rd_addr), .q(ram_q)
  );
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      rx_prev <= 1'b0; rx_acc <= 1'b0; rx_bad <= 1'b0; rx_len <= '0; rx_cnt <= '0;
      wr_ptr <= '0; cwr <= '0; pq_wr <= '0; drop_cnt <= '0;
    end else begin
      rx_prev <= bus.udp_rec_data_valid;
      if (ram_we) wr_ptr <= wr_ptr + B_ONE;
      if (sop) begin
        rx_acc <= accept; rx_bad <= bus.udp_rec_err; rx_len <= bus.udp_rec_data_length; rx_cnt <= 16'd1;
      end else if (bus.udp_rec_data_valid && rx_acc) begin
        rx_cnt <= rx_cnt < rx_len ? rx_cnt + 16'd1 : rx_cnt;
        rx_bad <= rx_bad || bus.udp_rec_err || rx_cnt == rx_len;
      end
      if (eop && rx_acc) begin
        rx_acc <= 1'b0;
        if (commit) begin
          pq_wr <= pq_wr + PQ_ONE; cwr <= wr_ptr;
        end else wr_ptr <= cwr;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
  always_ff @(posedge rgmii_clk) begin
    if (commit) pq[pq_wr[PQ_AW-1:0]] <= rx_len;
  end
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      pat_tmr <= '0; pat_pending <= 1'b0;
    end else begin
      pat_tmr <= tick ? '0 : pat_tmr + 32'd1;
      pat_pending <= (tick && (mode == MODE_PAT || mode == MODE_BOTH)) ||
                     (pat_pending && !(state == TX_REQ && src == SRC_PAT && bus.app_tx_ack));
    end
  end
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state <= TX_IDLE; src <= SRC_ECHO; tx_len <= '0; len_r <= '0; idx <= '0; gap <= '0;
      seq <= '0; rd_ptr <= '0; pq_rd <= '0; pkt_cnt <= '0;
    end else begin
      case (state)
        TX_IDLE: if (echo_go || pat_go) begin
          state <= TX_REQ; src <= echo_go ? SRC_ECHO : SRC_PAT; len_r <= nlen;
          tx_len <= nlen < 16'(MIN_TX_LEN) ? 16'(MIN_TX_LEN) : nlen;
        end
        TX_REQ: if (bus.app_tx_ack) begin
          state <= TX_SEND; idx <= '0;
        end
        TX_SEND: if (bus.app_tx_data_req) begin
          idx <= idx + 16'd1;
          if (last) begin
            state <= TX_GAP; gap <= '0; pkt_cnt <= pkt_cnt + 16'd1;
            if (src == SRC_ECHO) begin
              pq_rd <= pq_rd + PQ_ONE; rd_ptr <= rd_ptr + len_r[BUF_AW:0];
            end else seq <= seq + 8'd1;
          end
        end
        default: begin
          gap <= gap + 16'd1;
          if (gap == 16'(IFG_CYCLES - 1)) state <= TX_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge rgmii_clk) begin
    d_valid <= !rst && ram_re;
    d_pad <= idx >= len_r;
    d_pat <= src == SRC_PAT;
    d_byte <= seq + idx[7:0];
  end
endmodule

// File: tb/tb_udp_echo_buffer.sv
// tb_udp_echo_buffer: directed rx stimulus with a tx-engine model checking against an expectation queue
module tb_udp_echo_buffer;
  typedef logic [7:0] bq_t[$];
  logic rgmii_clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [15:0] pkt_cnt, drop_cnt;
  logic busy;
  int total = 0, bad = 0;
  int exp_len[$];
  logic [7:0] exp_data[$];
  bit tx_go = 1'b1;
  int tphase = 0, tlen = 0, tsent = 0, trcv = 0;
  logic [7:0] pat_seq = 8'd0;
  bq_t a, b, c;
  int n;
  udp_echo_buffer_if bus();
  udp_echo_buffer #(
    .BUF_AW(6), .PQ_AW(1), .MIN_TX_LEN(18), .PAT_LEN(8), .PAT_PERIOD(200), .IFG_CYCLES(12)
  ) dut (
    .rgmii_clk(rgmii_clk), .rst(rst), .mode(mode), .bus(bus),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );
  always #5 rgmii_clk = ~rgmii_clk;
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  function automatic bq_t ramp(input int len, input int base);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'(base + i));
    return q;
  endfunction
  task automatic push_echo(input bq_t d);
    int l = d.size() < 18 ? 18 : d.size();
    exp_len.push_back(l);
    for (int i = 0; i < l; i++) exp_data.push_back(i < d.size() ? d[i] : 8'h00);
  endtask
  task automatic push_pat();
    exp_len.push_back(18);
    for (int i = 0; i < 18; i++) exp_data.push_back(i < 8 ? 8'(pat_seq + i) : 8'h00);
    pat_seq++;
  endtask
  task automatic send(input bq_t d, input int err_at);
    foreach (d[i]) begin
      @(negedge rgmii_clk);
      bus.udp_rec_data_valid = 1'b1;
      bus.udp_rec_rdata = d[i];
      bus.udp_rec_data_length = 16'(d.size());
      bus.udp_rec_err = i == err_at;
    end
    @(negedge rgmii_clk);
    bus.udp_rec_data_valid = 1'b0;
    bus.udp_rec_err = 1'b0;
    bus.udp_rec_data_length = 16'd0;
    @(negedge rgmii_clk);
  endtask
  task automatic drain(input int max_cyc);
    int k = 0;
    while ((exp_len.size() != 0 || exp_data.size() != 0 || busy || tphase != 0) && k < max_cyc) begin
      @(negedge rgmii_clk);
      k++;
    end
    total++;
    if (k >= max_cyc) begin
      bad++;
      $display("FAIL drain timeout bytes_left=%0d want=0", exp_data.size());
    end
    repeat (2) @(negedge rgmii_clk);
  endtask
  // tx engine model: ack each request, pull app_tx_length bytes back to back, check each one
  initial begin
    bus.app_tx_ack = 1'b0;
    bus.app_tx_data_req = 1'b0;
    forever begin
      @(negedge rgmii_clk);
      if (rst) begin
        tphase = 0; bus.app_tx_ack = 1'b0; bus.app_tx_data_req = 1'b0;
      end else if (tphase == 0) begin
        if (tx_go && bus.app_tx_req) begin
          tlen = int'(bus.app_tx_length);
          check("tx_len", tlen, exp_len.size() != 0 ? exp_len.pop_front() : -1);
          bus.app_tx_ack = 1'b1;
          tphase = 1;
        end
      end else if (tphase == 1) begin
        bus.app_tx_ack = 1'b0; bus.app_tx_data_req = 1'b1;
        tsent = 1; trcv = 0; tphase = 2;
      end else begin
        check("tx_byte", int'(bus.app_tx_data), exp_data.size() != 0 ? int'(exp_data.pop_front()) : -1);
        trcv++;
        bus.app_tx_data_req = tsent < tlen;
        if (tsent < tlen) tsent++;
        if (trcv >= tlen) tphase = 0;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired bytes_left=%0d want=0", exp_data.size());
    $fatal(1, "watchdog");
  end
  initial begin
    bus.udp_rec_data_valid = 1'b0;
    bus.udp_rec_rdata = 8'h00;
    bus.udp_rec_data_length = 16'd0;
    bus.udp_rec_err = 1'b0;
    repeat (3) @(negedge rgmii_clk);
    check("rst_req", bus.app_tx_req, 0);
    check("rst_len", bus.app_tx_length, 0);
    check("rst_data", bus.app_tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt", pkt_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    a = ramp(32, 0);
    push_echo(a); send(a, -1); drain(400);
    check("pkt_after_32", pkt_cnt, 1);
    a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    push_echo(a); send(a, -1); drain(400);
    check("pkt_after_pad", pkt_cnt, 2);
    a = ramp(40, 8'h50);
    send(a, 20);
    check("drop_after_err", drop_cnt, 1);
    a = ramp(10, 8'hC0);
    push_echo(a); send(a, -1); drain(400);
    check("pkt_after_err", pkt_cnt, 3);
    check("drop_stable", drop_cnt, 1);
    tx_go = 1'b0;
    a = ramp(20, 8'h40); b = ramp(20, 8'h60); c = ramp(20, 8'h80);
    push_echo(a); push_echo(b);
    send(a, -1); send(b, -1); send(c, -1);
    check("drop_qfull", drop_cnt, 2);
    check("stall_req", bus.app_tx_req, 1);
    check("stall_len", bus.app_tx_length, 20);
    tx_go = 1'b1;
    drain(600);
    check("pkt_after_wrap", pkt_cnt, 5);
    tx_go = 1'b0;
    a = ramp(8, 8'h11);
    push_echo(a); send(a, -1);
    mode = 2'd2;
    b = ramp(20, 8'hA0);
    push_echo(b); send(b, -1);
    repeat (210) @(negedge rgmii_clk);
    check("pat_stall_req", bus.app_tx_req, 1);
    push_pat(); push_pat();
    tx_go = 1'b1;
    drain(3000);
    mode = 2'd0;
    check("pkt_after_pat", pkt_cnt, 9);
    a = ramp(32, 8'h20);
    push_echo(a); send(a, -1);
    n = 0;
    while (exp_data.size() >= 20 && n < 300) begin
      @(negedge rgmii_clk);
      n++;
    end
    check("mid_send_busy", busy, 1);
    rst = 1'b1;
    @(negedge rgmii_clk);
    check("rst_send_req", bus.app_tx_req, 0);
    check("rst_send_busy", busy, 0);
    check("rst_send_pkt", pkt_cnt, 0);
    check("rst_send_drop", drop_cnt, 0);
    @(negedge rgmii_clk);
    exp_len.delete();
    exp_data.delete();
    rst = 1'b0;
    a = ramp(10, 8'h33);
    push_echo(a); send(a, -1); drain(400);
    check("pkt_after_rst", pkt_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udp_echo_buffer.md
Name: udp_echo_buffer

Overview:
Packet-buffered UDP echo and traffic source placed between the UDP receive path and the UDP transmit engine of the GMII test design. It stores whole received UDP payloads in a circular byte buffer and commits only complete, error-free packets. Committed packets are echoed back. Optionally, the block also injects periodic test-pattern packets. Buffer depth, packet-queue depth, pattern size/period, minimum frame padding and inter-packet gap are parametrised.

Parameters:
BUF_AW, 11, byte-buffer address width; buffer holds 2^BUF_AW bytes
PQ_AW, 3, packet-length queue address width; at most 2^PQ_AW committed packets
MIN_TX_LEN, 18, minimum transmitted payload length; shorter packets are zero-padded
PAT_LEN, 64, pattern packet payload length in bytes (1..2^16-1)
PAT_PERIOD, 125_000_000, cycles between pattern ticks
IFG_CYCLES, 12, idle cycles enforced between transmitted packets

Ports:
rgmii_clk  in  1  single clock for the whole block
rst  in  1  synchronous, active-high reset
mode  in  2  0=echo only, 1=pattern only, 2=echo+pattern, 3=disabled (rx dropped, no tx)
udp_rec_data_valid  in  1  high for each received payload byte; packet ends when it falls
udp_rec_rdata  in  8  received payload byte
udp_rec_data_length  in  16  payload length, valid while udp_rec_data_valid is high
udp_rec_err  in  1  pulse: current rx packet is corrupt (CRC or checksum error)
app_tx_req  out  1  packet ready; held until app_tx_ack
app_tx_length  out  16  payload length; stable while app_tx_req is high and until the packet ends
app_tx_ack  in  1  one-cycle pulse from the tx engine accepting the request
app_tx_data_req  in  1  pull one payload byte
app_tx_data  out  8  payload byte, valid the cycle after app_tx_data_req
pkt_cnt  out  16  packets transmitted, wraps
drop_cnt  out  16  rx packets dropped, saturates at 16'hFFFF
busy  out  1  tx FSM not in IDLE

Behaviour:
- Reset: all outputs are 0. Buffer pointers, queue, pattern timer and pending flag are cleared. RAM contents are don't-care. Reset mid-packet abandons the packet; app_tx_req is low in the cycle after rst.
- RX, start of packet (first valid cycle): length L is sampled. The packet is accepted only if all hold: L != 0, L <= free bytes (2^BUF_AW minus bytes committed and not yet read), queue not full, mode is 0 or 2. Otherwise the rest of the packet is discarded and drop_cnt increments.
- RX, accepted packet: bytes are written at wr_ptr (wraps modulo 2^BUF_AW). At the falling edge of valid, the packet commits (push L to queue, committed_wr := wr_ptr) only if the byte count equals L and no udp_rec_err was seen. Otherwise wr_ptr rewinds to committed_wr and drop_cnt increments.
- RX, error after commit: udp_rec_err arriving after the packet has already committed is ignored.
- Pattern timer: counts PAT_PERIOD cycles; its tick sets pat_pending when mode is 1 or 2. Ticks arriving while pat_pending is set coalesce; there is no counter of missed ticks.
- Tx FSM states:
  - IDLE -> REQ when the queue is non-empty (echo has priority) or pat_pending is set. app_tx_length = max(len, MIN_TX_LEN).
  - REQ: app_tx_req high; -> SEND on app_tx_ack. A pattern-source selection clears pat_pending at the ack.
  - SEND: each app_tx_data_req returns one byte the next cycle (1-cycle synchronous RAM read).
    - Echo source: byte i < len comes from rd_ptr; bytes i >= len are 8'h00 padding.
    - Pattern source: byte i = (seq + i) mod 256; seq increments per pattern packet.
    - After app_tx_length requests: -> GAP. The echo queue pops, and rd_ptr advances by len (not the padded length). pkt_cnt increments.
  - GAP: IFG_CYCLES cycles -> IDLE.
- Extra app_tx_data_req outside SEND is ignored; app_tx_data is 0.
- Mode change takes effect at the next packet boundary. A packet in REQ/SEND always completes.
- Buffer and queue reads and writes in the same cycle are legal. Free space uses committed pointers only, so an exactly-full buffer (free=0) rejects any L>=1.

Decomposition:
- Package udp_echo_pkg: mode encodings (MODE_ECHO, MODE_PAT, MODE_BOTH, MODE_OFF), tx FSM state enum, source-select enum.
- One sub-module, udp_echo_ram: simple dual-port byte RAM, 2^BUF_AW x 8, registered read.
- The packet-length queue is inline: a 2^PQ_AW x 16 register array with pointers.

Test Plan:
- mode=0, rx 32-byte packet 0x00..0x1F -> one app_tx_req, length 32; after ack, 32 data_req return 0x00..0x1F; pkt_cnt=1.
- mode=0, rx 5-byte packet AA BB CC DD EE -> length 18; bytes AA..EE then 13 x 0x00.
- mode=0, udp_rec_err mid 40-byte packet, then valid 10-byte packet -> drop_cnt=1; only the 10-byte packet is echoed, data intact.
- BUF_AW=6, PQ_AW=1: three 20-byte packets back-to-back with tx stalled (no ack) -> first two committed, third dropped (queue full); drop_cnt=1. Release ack -> two echoes with correct data across pointer wrap.
- mode=2, PAT_PERIOD=200, PAT_LEN=8, rx packet arrives simultaneously with a tick -> echo sent first; pattern follows after IFG_CYCLES with bytes 00..07, the next one 01..08.
- rst asserted during SEND -> app_tx_req=0, busy=0, pkt_cnt=0 next cycle; a new packet afterward echoes correctly.
